// File: rtl/store_entry_controller.sv
// Front-panel store entry controller: debounces the panel buttons, keeps them as
// toggle switches and sequences single-word writes (manual or auto) into the store.
module store_entry_controller #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_btn,
    input  logic [ADDR_W-1:0] addr_btn,
    input  logic              clear_btn,
    input  logic              write_btn,
    input  logic              mode_btn,
    input  logic [ADDR_W-1:0] auto_addr,
    input  logic [WIDTH-1:0]  auto_data,
    input  logic              auto_valid,
    output logic              auto_ready,
    output logic [ADDR_W-1:0] store_addr,
    output logic [WIDTH-1:0]  store_data,
    output logic              store_we,
    input  logic              store_ack,
    output logic              manual_mode,
    output logic [WIDTH-1:0]  data_sw,
    output logic [ADDR_W-1:0] addr_sw,
    output logic              busy
);

    // All buttons are handled as one vector: data, address, clear, write, mode.
    localparam int unsigned NB = WIDTH + ADDR_W + 3;
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] deb_q, deb_d;
    logic [NB-1:0] press;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    logic [WIDTH-1:0]  data_press;
    logic [ADDR_W-1:0] addr_press;
    logic              clear_press, write_press, mode_press;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_sw_q, data_sw_d;
    logic [ADDR_W-1:0] addr_sw_q, addr_sw_d;
    logic [ADDR_W-1:0] store_addr_q, store_addr_d;
    logic [WIDTH-1:0]  store_data_q, store_data_d;
    logic              manual_q, manual_d;
    logic              pending_q, pending_d;
    logic              pending_next;

    assign btn_raw = {mode_btn, write_btn, clear_btn, addr_btn, data_btn};

    assign data_press  = press[WIDTH-1:0];
    assign addr_press  = press[WIDTH +: ADDR_W];
    assign clear_press = press[WIDTH + ADDR_W];
    assign write_press = press[WIDTH + ADDR_W + 1];
    assign mode_press  = press[WIDTH + ADDR_W + 2];

    // Debounce: accept a level change after DEBOUNCE consecutive disagreeing cycles;
    // the press pulse fires on the same cycle a 0->1 change is accepted.
    always_comb begin
        deb_d = deb_q;
        press = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Toggle switches; clear overrides data toggles in the same cycle.
    always_comb begin
        data_sw_d = clear_press ? '0 : (data_sw_q ^ data_press);
        addr_sw_d = addr_sw_q ^ addr_press;
    end

    // Write sequencer next-state: mode pulse in idle blocks both write sources.
    always_comb begin
        state_d      = state_q;
        store_addr_d = store_addr_q;
        store_data_d = store_data_q;
        manual_d     = manual_q;
        pending_d    = pending_q;
        pending_next = pending_q ^ mode_press;
        auto_ready   = (state_q == StIdle) && !manual_q && !mode_press && !pending_q;
        unique case (state_q)
            StIdle: begin
                if (mode_press) begin
                    manual_d = !manual_q;
                end else if (manual_q && write_press) begin
                    store_addr_d = addr_sw_q;
                    store_data_d = data_sw_q;
                    state_d      = StWrite;
                end else if (auto_ready && auto_valid) begin
                    store_addr_d = auto_addr;
                    store_data_d = auto_data;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                pending_d = pending_next;
                if (store_ack) begin
                    // A deferred mode change lands as the sequencer returns to idle.
                    manual_d  = manual_q ^ pending_next;
                    pending_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Synchronisers, debounce state, switches and sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            data_sw_q    <= '0;
            addr_sw_q    <= '0;
            store_addr_q <= '0;
            store_data_q <= '0;
            manual_q     <= 1'b1;
            pending_q    <= 1'b0;
            state_q      <= StIdle;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            data_sw_q    <= data_sw_d;
            addr_sw_q    <= addr_sw_d;
            store_addr_q <= store_addr_d;
            store_data_q <= store_data_d;
            manual_q     <= manual_d;
            pending_q    <= pending_d;
            state_q      <= state_d;
        end
    end

    assign store_we    = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign store_addr  = store_addr_q;
    assign store_data  = store_data_q;
    assign manual_mode = manual_q;
    assign data_sw     = data_sw_q;
    assign addr_sw     = addr_sw_q;

endmodule

// File: tb/tb_store_entry_controller.sv
// Bench for store_entry_controller: directed panel scenarios plus randomized button
// traffic, with store writes checked by a scoreboard monitor.
module tb_store_entry_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_btn = '0;
    logic [4:0]  addr_btn = '0;
    logic        clear_btn = 1'b0, write_btn = 1'b0, mode_btn = 1'b0;
    logic [4:0]  auto_addr = '0;
    logic [31:0] auto_data = '0;
    logic        auto_valid = 1'b0;
    logic        auto_ready;
    logic [4:0]  store_addr;
    logic [31:0] store_data;
    logic        store_we;
    logic        store_ack = 1'b0;
    logic        manual_mode;
    logic [31:0] data_sw;
    logic [4:0]  addr_sw;
    logic        busy;

    store_entry_controller #(.WIDTH(32), .ADDR_W(5), .DEBOUNCE(4)) dut (
        .clk(clk), .rst(rst), .data_btn(data_btn), .addr_btn(addr_btn),
        .clear_btn(clear_btn), .write_btn(write_btn), .mode_btn(mode_btn),
        .auto_addr(auto_addr), .auto_data(auto_data), .auto_valid(auto_valid),
        .auto_ready(auto_ready), .store_addr(store_addr), .store_data(store_data),
        .store_we(store_we), .store_ack(store_ack), .manual_mode(manual_mode),
        .data_sw(data_sw), .addr_sw(addr_sw), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    logic ack_force = 1'b0;
    logic ack_rand = 1'b0;

    // Reference model of the panel, at the level of switches and mode.
    logic [31:0] m_data = '0;
    logic [4:0]  m_addr = '0;
    logic        m_manual = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Store side: ack drawn a little after each edge while a write is requested.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            store_ack = store_we && (ack_force || (ack_rand && ($urandom_range(0, 2) == 0)));
        end
    end

    // Scoreboard monitor: every completed write must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && store_we && store_ack) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", {27'd0, store_addr, store_data}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_addr", 64'(store_addr), 64'(e.a));
                    check("sb_data", 64'(store_data), 64'(e.d));
                    check("sb_busy", 64'(busy), 64'd1);
                end
            end
        end
    end

    task automatic press(input logic [31:0] dm, input logic [4:0] am, input logic clr,
                         input logic wr, input logic md);
        @(posedge clk); #1;
        data_btn = dm; addr_btn = am; clear_btn = clr; write_btn = wr; mode_btn = md;
        repeat (8) @(posedge clk);
        #1;
        data_btn = '0; addr_btn = '0; clear_btn = 1'b0; write_btn = 1'b0; mode_btn = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    // Release a held write: one ack cycle, then confirm the request dropped.
    task automatic do_ack();
        @(posedge clk); #1;
        ack_force = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("we_after_ack", 64'(store_we), 64'd0);
        check("busy_after_ack", 64'(busy), 64'd0);
        ack_force = 1'b0;
    endtask

    task automatic check_sw(input string tag);
        @(negedge clk);
        check({tag, "_data_sw"}, 64'(data_sw), 64'(m_data));
        check({tag, "_addr_sw"}, 64'(addr_sw), 64'(m_addr));
        check({tag, "_manual"}, 64'(manual_mode), 64'(m_manual));
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  ra;
        int          op;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data_sw", 64'(data_sw), 64'd0);
        check("rst_addr_sw", 64'(addr_sw), 64'd0);
        check("rst_we", 64'(store_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_manual", 64'(manual_mode), 64'd1);
        check("rst_ready", 64'(auto_ready), 64'd0);
        check("rst_store", {27'd0, store_addr, store_data}, 64'd0);

        // Debounce latency: change lands exactly 6 cycles after the raw rise.
        @(posedge clk); #1 data_btn[3] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("deb_early", 64'(data_sw), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("deb_on_time", 64'(data_sw), 64'h8);
        repeat (4) @(posedge clk);
        #1 data_btn[3] = 1'b0;
        repeat (10) @(posedge clk);
        m_data = 32'h8;
        check_sw("release");

        // Short glitch must be filtered.
        @(posedge clk); #1 data_btn[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 data_btn[0] = 1'b0;
        repeat (10) @(posedge clk);
        check_sw("glitch");

        // Clear wins over a simultaneous data toggle.
        press(32'h2, 5'd0, 1'b1, 1'b0, 1'b0);
        m_data = '0;
        check_sw("clear");

        // Manual write held until ack.
        press(32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b0);
        m_data = 32'hDEADBEEF; m_addr = 5'd5;
        check_sw("setup");
        sb_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        press('0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("man_we", 64'(store_we), 64'd1);
        check("man_addr", 64'(store_addr), 64'd5);
        check("man_data", 64'(store_data), 64'hDEADBEEF);
        do_ack();

        // Switch to auto mode and insert one word.
        press('0, '0, 1'b0, 1'b0, 1'b1);
        m_manual = 1'b0;
        check_sw("to_auto");
        check("auto_ready_idle", 64'(auto_ready), 64'd1);
        @(posedge clk); #1;
        auto_valid = 1'b1; auto_addr = 5'd31; auto_data = 32'h1;
        sb_q.push_back('{a: 5'd31, d: 32'h1});
        @(posedge clk); #1 auto_valid = 1'b0;
        @(negedge clk);
        check("auto_ready_busy", 64'(auto_ready), 64'd0);
        check("auto_busy", 64'(busy), 64'd1);
        check("auto_addr", 64'(store_addr), 64'd31);
        check("auto_data", 64'(store_data), 64'h1);
        repeat (3) @(posedge clk);
        do_ack();

        // Mode press during a write is deferred until the write completes.
        @(posedge clk); #1;
        auto_valid = 1'b1; auto_addr = 5'd12; auto_data = 32'hCAFE0001;
        sb_q.push_back('{a: 5'd12, d: 32'hCAFE0001});
        @(posedge clk); #1 auto_valid = 1'b0;
        press('0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("pending_hold", 64'(manual_mode), 64'd0);
        do_ack();
        check("pending_applied", 64'(manual_mode), 64'd1);
        m_manual = 1'b1;

        // Two mode presses cancel; a write press during a write is dropped.
        sb_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        press('0, '0, 1'b0, 1'b1, 1'b0);
        press('0, '0, 1'b0, 1'b0, 1'b1);
        press('0, '0, 1'b0, 1'b0, 1'b1);
        press('0, '0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("cancel_busy", 64'(busy), 64'd1);
        do_ack();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("cancel_manual", 64'(manual_mode), 64'd1);
        check("dropped_write", 64'(busy), 64'd0);
        check("sb_empty_mid", 64'(sb_q.size()), 64'd0);

        // Reset in the middle of a write abandons it.
        sb_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        press('0, '0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstw_we", 64'(store_we), 64'd0);
        check("rstw_manual", 64'(manual_mode), 64'd1);
        check("rstw_data_sw", 64'(data_sw), 64'd0);
        check("rstw_busy", 64'(busy), 64'd0);
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        m_data = '0; m_addr = '0; m_manual = 1'b1;

        // Randomized panel traffic with random ack latency.
        ack_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 5));
            rd = $urandom;
            ra = 5'($urandom);
            case (op)
                0: begin press(rd, '0, 1'b0, 1'b0, 1'b0); m_data ^= rd; end
                1: begin press('0, ra, 1'b0, 1'b0, 1'b0); m_addr ^= ra; end
                2: begin press(rd, '0, 1'b1, 1'b0, 1'b0); m_data = '0; end
                3: begin
                    if (m_manual) sb_q.push_back('{a: m_addr, d: m_data});
                    press('0, '0, 1'b0, 1'b1, 1'b0);
                end
                4: begin press('0, '0, 1'b0, 1'b0, 1'b1); m_manual = !m_manual; end
                default: begin
                    @(posedge clk); #1;
                    auto_valid = 1'b1; auto_addr = ra; auto_data = rd;
                    if (!m_manual) sb_q.push_back('{a: ra, d: rd});
                    @(negedge clk);
                    check("rnd_auto_ready", 64'(auto_ready), 64'(!m_manual));
                    @(posedge clk); #1 auto_valid = 1'b0;
                end
            endcase
            wait_idle();
            check_sw("rnd");
        end

        wait_idle();
        repeat (3) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
